// File: rtl/row_packer_pkg.sv
// Shared helpers for the row packer: counter sizing used by the top and by
// the wrap counter it instantiates.
package row_packer_pkg;

  // Bits needed to hold 0..n-1, never less than one bit so a single-state
  // counter still has a real (constant-zero) register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_packer_counter_wrap.sv
// Up-counter that wraps to zero after reaching max_p. wrap_o pulses in the
// cycle whose increment causes the wrap, so it can enable a chained counter.
module counter_wrap
  import row_packer_pkg::*;
#(
  parameter int max_p   = 3,
  parameter int width_p = cnt_width(max_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o,
  output logic               wrap_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);

  logic at_max;

  // Wrap is detected by comparing against the limit, so any max_p works,
  // not just 2**n-1.
  always_comb begin
    at_max = (count_o == max_lp);
    wrap_o = en_i & at_max;
  end

  // Count register: advance on enable, fold back to zero at the limit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= at_max ? '0 : count_o + 1'b1;
    end
  end

endmodule

// File: rtl/row_packer.sv
// Packs num_p consecutive FIFO elements into one row word. Elements are
// collected in asm_r while the previous row sits in the output register, so
// a row can be loaded in the same cycle the old one drains.
//
// Handshakes:
//   input side  : valid/yumi. valid_i says data_i holds an element; yumi_o
//                 is the consume strobe and is only ever raised while
//                 valid_i is high. The element is taken on the rising edge
//                 of a cycle with yumi_o=1.
//   output side : valid/ready. A row transfers on each rising edge with
//                 valid_o & ready_i. While valid_o is high and ready_i is
//                 low, data_o and last_o hold steady.
module row_packer
  import row_packer_pkg::*;
#(
  parameter int width_p = 8,
  parameter int num_p   = 4,
  parameter int rows_p  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     yumi_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [num_p*width_p-1:0] data_o,
  output logic                     last_o
);

  localparam int elem_w_lp = cnt_width(num_p);
  localparam int row_w_lp  = cnt_width(rows_p);

  localparam logic [elem_w_lp-1:0] elem_max_lp = elem_w_lp'(num_p - 1);
  localparam logic [row_w_lp-1:0]  row_max_lp  = row_w_lp'(rows_p - 1);

  logic [elem_w_lp-1:0]     elem_cnt_r;
  logic [row_w_lp-1:0]      row_cnt_r;
  logic                     elem_last;
  logic                     row_last;
  logic                     row_complete;
  logic                     row_wrap;
  logic                     drain_w;
  logic [num_p*width_p-1:0] row_word;

  // The tile-end pulse equals row_last at the completing accept; last_o is
  // taken from the row count compare instead, so the pulse goes unread.
  logic unused_tile_wrap;
  assign unused_tile_wrap = row_wrap;

  // Only the row-completing element can stall: it needs the output register,
  // which is free unless a row is waiting and not being drained this cycle.
  always_comb begin
    elem_last = (elem_cnt_r == elem_max_lp);
    row_last  = (row_cnt_r == row_max_lp);
    drain_w   = valid_o & ready_i;
    yumi_o    = valid_i & ~(elem_last & valid_o & ~ready_i);
  end

  // Element slot counter; its wrap pulse marks the row-completing accept.
  counter_wrap #(
    .max_p   (num_p - 1),
    .width_p (elem_w_lp)
  ) u_elem_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (yumi_o),
    .count_o (elem_cnt_r),
    .wrap_o  (row_complete)
  );

  // Row-within-tile counter, advanced once per completed row.
  counter_wrap #(
    .max_p   (rows_p - 1),
    .width_p (row_w_lp)
  ) u_row_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (row_complete),
    .count_o (row_cnt_r),
    .wrap_o  (row_wrap)
  );

  if (num_p > 1) begin : g_asm
    logic [(num_p-1)*width_p-1:0] asm_r;

    // Assembly buffer: element k of the row is parked in slot k until the
    // final element arrives and the whole row moves to data_o.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        asm_r <= '0;
      end else if (yumi_o && !elem_last) begin
        for (int k = 0; k < num_p - 1; k++) begin
          if (elem_cnt_r == elem_w_lp'(k)) begin
            asm_r[k*width_p +: width_p] <= data_i;
          end
        end
      end
    end

    assign row_word = {data_i, asm_r};
  end else begin : g_no_asm
    // A one-element row needs no assembly; every accept completes a row.
    assign row_word = data_i;
  end

  // Output register: load a completed row (even while the old one drains,
  // so back-to-back rows have no bubble), otherwise clear valid on drain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
    end else if (row_complete) begin
      valid_o <= 1'b1;
      data_o  <= row_word;
      last_o  <= row_last;
    end else if (drain_w) begin
      valid_o <= 1'b0;
    end
  end

endmodule
